// File: rtl/button_pkg.sv
// Shared types and defaults for the button conditioner.
// Holds the per-channel state enum, default timing constants and a counter-width helper.
// Pure declarations, no logic.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int REPEAT_DELAY_DEF    = 25000000;
    localparam int REPEAT_RATE_DEF     = 5000000;

    // Bits needed to hold max_val with one bit of headroom, never truncating.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, auto-repeat counter.
// Latency: press/release pulse DEBOUNCE_CYCLES+3 cycles after the first edge sampling the new level.
// No backpressure: pulses are one-cycle events, never held or queued.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    // The repeat counter folds back from the last cycle of a period to
    // REPEAT_DELAY, so it stays bounded and periodic for any hold length.
    localparam int REP_TOP = (REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY + REPEAT_RATE - 1;
    localparam int DEB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int REP_W   = cnt_width(REP_TOP);

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REP_TOP);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);

    btn_state_e       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;

    // State register: every flop, cleared asynchronously so a reset discards any pending event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            deb_cnt_q <= '0;
            rep_cnt_q <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    // Next state: synchronizer shift, debounce counting and repeat counting.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        rep_cnt_d = rep_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d   = ST_DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_PRESSED;
                    rep_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sync2_q) begin
                    state_d   = ST_DEB_RELEASE;
                    deb_cnt_d = '0;
                end else if (REPEAT_DELAY != 0) begin
                    rep_cnt_d = (rep_cnt_q == REP_LAST) ? REP_FIRST : rep_cnt_q + 1'b1;
                end
            end
            ST_DEB_RELEASE: begin
                // rep_cnt holds here so a bounce back keeps the repeat phase.
                if (sync2_q) begin
                    state_d = ST_PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: pulses are set on the transition edge and registered.
    always_comb begin
        press_d   = (state_q == ST_DEB_PRESS) && (state_d == ST_PRESSED);
        release_d = (state_q == ST_DEB_RELEASE) && (state_d == ST_IDLE);
        repeat_d  = (REPEAT_DELAY != 0) && (state_q == ST_PRESSED) &&
                    (state_d == ST_PRESSED) && (rep_cnt_d == REP_FIRST);
    end

    assign btn_level   = (state_q == ST_PRESSED) || (state_q == ST_DEB_RELEASE);
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent debounced button channels with press/release/auto-repeat pulses.
// Latency: DEBOUNCE_CYCLES+3 cycles from raw edge to press/release pulse.
// No backpressure: outputs are level and single-cycle pulses only.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus random bouncing,
// scored against a run-length reference model through an expectation queue.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] rpt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_press_seen = 0;
    int   n_repeat_seen = 0;

    task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, want);
        end
    endtask

    // Reference model: a level change is accepted once the synchronized input
    // has disagreed with the accepted level for D+1 consecutive edges; held
    // counts edges spent steadily pressed, and repeats fire at RD, RD+RR, ...
    int m_s1[N], m_s2[N], m_level[N], m_run[N], m_held[N];

    always @(posedge clk) begin
        exp_t e;
        e.lvl = '0; e.prs = '0; e.rel = '0; e.rpt = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (reset) begin
                m_s1[ch] = 0; m_s2[ch] = 0; m_level[ch] = 0;
                m_run[ch] = 0; m_held[ch] = 0;
            end else begin
                int sync_v, prev_run;
                sync_v   = m_s2[ch];
                prev_run = m_run[ch];
                m_run[ch] = (sync_v != m_level[ch]) ? m_run[ch] + 1 : 0;
                if (m_run[ch] == D + 1) begin
                    m_level[ch] = sync_v;
                    m_run[ch]   = 0;
                    if (sync_v == 1) begin
                        e.prs[ch]  = 1'b1;
                        m_held[ch] = 0;
                    end else begin
                        e.rel[ch] = 1'b1;
                    end
                end else if (m_level[ch] == 1 && sync_v == 1 && prev_run == 0) begin
                    m_held[ch]++;
                    if (RD != 0 && m_held[ch] >= RD && (m_held[ch] - RD) % RR == 0)
                        e.rpt[ch] = 1'b1;
                end
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = int'(btn_raw[ch]);
            end
            e.lvl[ch] = (m_level[ch] == 1);
        end
        exp_q.push_back(e);
    end

    // Monitor: every cycle the DUT presents its outputs; pop and compare.
    always @(negedge clk) begin
        exp_t w;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("level",   btn_level,   w.lvl);
            chk("press",   btn_press,   w.prs);
            chk("release", btn_release, w.rel);
            chk("repeat",  btn_repeat,  w.rpt);
            chk("press_repeat_overlap", btn_press & btn_repeat, '0);
            if (btn_press != '0)  n_press_seen++;
            if (btn_repeat != '0) n_repeat_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_level",   btn_level,   '0);
        chk("rst_press",   btn_press,   '0);
        chk("rst_release", btn_release, '0);
        chk("rst_repeat",  btn_repeat,  '0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(3);
        reset = 1'b0;
        step(2);

        // Clean press on channel 0.
        btn_raw[0] = 1'b1; step(30);
        btn_raw[0] = 1'b0; step(10);

        // Short glitch on channel 1.
        btn_raw[1] = 1'b1; step(3);
        btn_raw[1] = 1'b0; step(10);

        // Long hold with auto-repeat on channel 2.
        btn_raw[2] = 1'b1; step(50);
        btn_raw[2] = 1'b0; step(12);

        // Release bounce while pressed on channel 0.
        btn_raw[0] = 1'b1; step(20);
        btn_raw[0] = 1'b0; step(2);
        btn_raw[0] = 1'b1; step(25);
        btn_raw[0] = 1'b0; step(10);

        // Reset in the middle of a press debounce, button still held.
        btn_raw[0] = 1'b1; step(4);
        pulse_reset();
        step(30);
        btn_raw[0] = 1'b0; step(10);

        // Simultaneous presses on channels 3 and 4.
        btn_raw[4:3] = 2'b11; step(10);
        btn_raw[4:3] = 2'b00; step(10);

        // Random bouncing: a fast-toggle phase, then a slow phase with long holds.
        for (int c = 0; c < 1600; c++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, (c < 800) ? 7 : 39) == 0)
                    btn_raw[ch] = ~btn_raw[ch];
            if ($urandom_range(0, 499) == 0)
                pulse_reset();
            step(1);
        end
        btn_raw = '0;
        step(12);

        @(negedge clk);
        #1;
        chk("queue_drained", N'(exp_q.size()), '0);
        chk("press_activity",  N'(n_press_seen  > 0), N'(1));
        chk("repeat_activity", N'(n_repeat_seen > 0), N'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
